div_seq: RTL
============

Name: div_seq

Overview:
Sequential restoring shift-subtract divider computing quot = dividend / divisor and rem = dividend % divisor. It is the inverse companion of the team's shift-add multipliers. Operand widths mirror the multiplier: a 2*size dividend (the product width) and a size-bit divisor. One quotient bit is produced per clock, under a start/done handshake.

Parameters:
size, 8, divisor/remainder width; dividend and quotient are 2*size bits

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk when ready=1
dividend  input  2*size  numerator; captured when start is accepted
divisor  input  size  denominator; captured when start is accepted
ready  output  1  block is idle (IDLE or DONE) and can accept start
done  output  1  result valid; held until next accepted start or reset
quot  output  2*size  quotient
rem  output  size  remainder
dbz  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ready=1; done=0; dbz=0; quot=0; rem=0; internal counter and partial remainder cleared.
- Reset mid-operation aborts immediately, with no result. After release the block is in IDLE.
- States:
  - IDLE: ready=1, done=0. start=1 -> BUSY.
  - BUSY: ready=0. Iterates 2*size times -> DONE.
  - DONE: ready=1, done=1, outputs stable. start=1 -> BUSY, and done drops on that same edge.
- Accept edge E0 captures dividend and divisor, loads a (size+1)-bit partial remainder with 0, and sets the counter to 0.
- Each BUSY edge performs one step:
  - shift the partial remainder left by one, bringing in the next dividend bit (MSB first);
  - if partial >= divisor, subtract the divisor and set the quotient bit to 1; else the quotient bit is 0.
- Edge E(2*size) performs the final step and enters DONE. quot, rem, dbz and done are registered on that edge.
- Latency: done rises exactly 2*size cycles after the accept edge (16 for size=8). Latency is fixed and independent of the data.
- start while BUSY (ready=0) is ignored, with no effect on the operation in flight.
- quot and rem hold the last result through IDLE/DONE. They are undefined-but-stable while BUSY and must not be sampled then.
- Arithmetic is unsigned. The remainder is always < divisor when divisor != 0.
- Divisor = 0: the block still takes the full 2*size cycles. Result: quot = all ones, rem = dividend[size-1:0] (low size bits), dbz=1. dbz=0 for every nonzero divisor.
- A dividend whose true quotient needs more than size bits is legal and exact, because quot is 2*size wide.

Optional Feature:
DIV_SIGNED_EN
- Defined: operands are two's complement.
  - At accept, magnitudes are taken.
  - At the DONE edge, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend (truncation toward zero).
  - Latency is unchanged.
  - Most-negative dividend / -1: quot = most-negative value (wraps), rem = 0, dbz=0.
  - Divisor = 0: quot = all ones (-1), rem = dividend low size bits, dbz=1.
- Undefined: unsigned behaviour only, as described above.

Test Plan:
1. size=8, dividend=1000, divisor=7, start one cycle -> done after exactly 16 cycles; quot=142, rem=6, dbz=0; ready=0 during BUSY.
2. dividend=16'hFFFF, divisor=1 -> quot=16'hFFFF, rem=0. Then dividend=5, divisor=200 -> quot=0, rem=5.
3. dividend=300, divisor=0 -> quot=16'hFFFF, rem=8'h2C, dbz=1. Next op 300/3 -> quot=100, rem=0, dbz=0.
4. Start 1000/7, pulse start with 50/5 at cycle 5 -> second request ignored; result 142 r 6. Start 50/5 in DONE -> done drops next edge, quot=10 and rem=0 after 16 cycles.
5. Assert rst_n=0 at cycle 8 of an operation -> outputs zero and ready=1 immediately. After release, 77/7 completes normally with quot=11, rem=0.
6. With DIV_SIGNED_EN: -100/7 -> quot=-14, rem=-2. 100/-7 -> quot=-14, rem=2. 16'h8000/-1 -> quot=16'h8000, rem=0.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: sequential restoring shift-subtract divider.
//   quot = dividend / divisor, rem = dividend % divisor. One quotient bit
//   per clock. The latency is fixed at 2*size cycles from accept to done.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             request, accepted on a rising edge while ready=1
//   dividend[2*size]  numerator, captured on accept
//   divisor[size]     denominator, captured on accept
//   ready             idle (IDLE or DONE), can accept start
//   done              result valid, held until next accept or reset
//   quot[2*size]      quotient
//   rem[size]         remainder
//   dbz               divide-by-zero flag for the current result
//
// Optional feature macro: DIV_SIGNED_EN
//   When defined, the operands are two's complement. Magnitudes are divided,
//   then the signs are fixed on the DONE edge (truncation toward zero).
//   When undefined, the divider is unsigned only.
module div_seq #(
    parameter int size = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2*size-1:0] dividend,
    input  logic [size-1:0]   divisor,
    output logic              ready,
    output logic              done,
    output logic [2*size-1:0] quot,
    output logic [size-1:0]   rem,
    output logic              dbz
);
    localparam int W  = 2 * size;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_dvd;     // dividend magnitude, shifted out MSB first
    logic [size-1:0] r_dvs;     // divisor magnitude
    logic [size-1:0] r_part;    // partial remainder; always < divisor between steps
    logic [W-1:0]    r_q;       // quotient bits collected so far
    logic [size-1:0] r_dlo;     // original dividend low bits, used for the dbz result
    logic            r_negq;    // quotient must be negated
    logic            r_negr;    // remainder must be negated
    logic [W-1:0]    r_quot;
    logic [size-1:0] r_rem;
    logic            r_dbz;

    logic            w_accept, w_last, w_ge, w_zero;
    logic [size:0]   w_sh, w_part_nx;
    logic [W-1:0]    w_q_nx, w_dvd_mag, w_quot_fin;
    logic [size-1:0] w_dvs_mag, w_rem_fin;

    assign ready    = (r_state != BUSY);
    assign done     = (r_state == DONE);
    assign quot     = r_quot;
    assign rem      = r_rem;
    assign dbz      = r_dbz;

    assign w_accept = start && ready;
    assign w_last   = (r_cnt == CW'(W - 1));
    assign w_zero   = (r_dvs == '0);

    // One restoring step: the step value is size+1 bits so that the
    // shifted-in bit can never be lost before the compare.
    assign w_sh      = {r_part, r_dvd[W-1]};
    assign w_ge      = (w_sh >= {1'b0, r_dvs});
    assign w_part_nx = w_ge ? (w_sh - {1'b0, r_dvs}) : w_sh;
    assign w_q_nx    = {r_q[W-2:0], w_ge};

`ifdef DIV_SIGNED_EN
    assign w_dvd_mag  = dividend[W-1] ? (-dividend) : dividend;
    assign w_dvs_mag  = divisor[size-1] ? (-divisor) : divisor;
    assign w_quot_fin = w_zero ? '1 : (r_negq ? (-w_q_nx) : w_q_nx);
    assign w_rem_fin  = w_zero ? r_dlo
                               : (r_negr ? (-w_part_nx[size-1:0]) : w_part_nx[size-1:0]);
`else
    assign w_dvd_mag  = dividend;
    assign w_dvs_mag  = divisor;
    assign w_quot_fin = w_zero ? '1 : w_q_nx;
    assign w_rem_fin  = w_zero ? r_dlo : w_part_nx[size-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = BUSY;
            BUSY:    if (w_last) w_state_nx = DONE;
            DONE:    if (start) w_state_nx = BUSY;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_part <= '0;
            r_q    <= '0;
            r_dlo  <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_dvd  <= w_dvd_mag;
            r_dvs  <= w_dvs_mag;
            r_part <= '0;
            r_q    <= '0;
            r_dlo  <= dividend[size-1:0];
            r_negq <= dividend[W-1] ^ divisor[size-1];
            r_negr <= dividend[W-1];
        end else if (r_state == BUSY) begin
            r_cnt  <= r_cnt + 1'b1;
            r_dvd  <= {r_dvd[W-2:0], 1'b0};
            // With a zero divisor the step value can carry into bit size;
            // that bit is dropped, and the result is overridden anyway.
            r_part <= w_part_nx[size-1:0];
            r_q    <= w_q_nx;
            if (w_last) begin
                r_quot <= w_quot_fin;
                r_rem  <= w_rem_fin;
                r_dbz  <= w_zero;
            end
        end
    end
endmodule
